// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch display front end: display mode
// encodings and the default blink half-period for a 100 MHz clock.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        MODE_SOLID       = 2'd0,
        MODE_ZERO_FLASH  = 2'd1,
        MODE_FORCE_FLASH = 2'd2,
        MODE_BLANK       = 2'd3
    } mode_e;

    localparam int unsigned DEFAULT_HALF_PERIOD = 25_000_000;

endpackage

// File: rtl/blink_tick_gen.sv
// Blink half-period divider. Produces the on/off phase plus a pulse on the
// cycle whose edge turns the phase back on (one full blink completed).
module blink_tick_gen
    import stopwatch_pkg::*;
#(
    parameter int unsigned HALF_PERIOD = DEFAULT_HALF_PERIOD
) (
    input  logic clock_i,
    input  logic reset_i,
    input  logic enable_i,
    input  logic restart_i,
    output logic phase_o,
    output logic eff_phase_o,
    output logic rise_o
);
    localparam int unsigned   DW       = $clog2(HALF_PERIOD);
    localparam logic [DW-1:0] DIV_LAST = DW'(HALF_PERIOD - 1);

    logic [DW-1:0] div_q, div_d, div_cur;
    logic          phase_q, phase_d, phase_cur;

    // A restart behaves as if the divider were already cleared this cycle,
    // so the first off-toggle still lands HALF_PERIOD cycles later.
    always_comb begin
        div_cur   = restart_i ? '0 : div_q;
        phase_cur = restart_i ? 1'b1 : phase_q;
        div_d     = '0;
        phase_d   = 1'b1;
        rise_o    = 1'b0;
        if (enable_i) begin
            if (div_cur == DIV_LAST) begin
                div_d   = '0;
                phase_d = ~phase_cur;
                rise_o  = ~phase_cur;
            end else begin
                div_d   = div_cur + DW'(1);
                phase_d = phase_cur;
            end
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            div_q   <= '0;
            phase_q <= 1'b1;
        end else begin
            div_q   <= div_d;
            phase_q <= phase_d;
        end
    end

    assign phase_o     = phase_q;
    assign eff_phase_o = phase_cur;

endmodule

// File: rtl/stopwatch_blink_ctrl.sv
// Per-digit display enable generator: zero-flash, forced flash, solid and
// blank modes, an edit-cursor blink mask and an optional finite flash burst.
module stopwatch_blink_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned HALF_PERIOD  = DEFAULT_HALF_PERIOD,
    parameter int unsigned N_DIGITS     = 4,
    parameter int unsigned BURST_CYCLES = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  count_up_enable,
    input  logic                  count_down_enable,
    input  logic [4*N_DIGITS-1:0] digits,
    input  logic [1:0]            mode,
    input  logic [N_DIGITS-1:0]   edit_mask,
    output logic [N_DIGITS-1:0]   digit_en,
    output logic                  blink_phase,
    output logic                  burst_done
);
    localparam int unsigned   BW         = $clog2(BURST_CYCLES + 2);
    localparam logic [BW-1:0] BURST_LAST = BW'(BURST_CYCLES);

    mode_e               mode_cur;
    logic                at_zero, running, is_blank, flash_req, edit_on;
    logic                phase_active, restart, eff_phase, rise;
    logic                flash_req_q, burst_latched_q, burst_latched_d;
    logic                burst_done_q, burst_done_d;
    logic [1:0]          mode_q;
    logic [N_DIGITS-1:0] edit_mask_q, digit_en_q, digit_en_d;
    logic [BW-1:0]       burst_cnt_q, burst_cnt_d;

    assign mode_cur = mode_e'(mode);
    assign at_zero  = (digits == '0);
    assign running  = count_up_enable | count_down_enable;
    assign is_blank = (mode_cur == MODE_BLANK);

    always_comb begin
        flash_req = 1'b0;
        case (mode_cur)
            MODE_ZERO_FLASH:  flash_req = at_zero & ~running;
            MODE_FORCE_FLASH: flash_req = 1'b1;
            default:          flash_req = 1'b0;
        endcase
    end

    assign edit_on      = (edit_mask != '0) && !is_blank;
    assign phase_active = (flash_req && !burst_latched_q) || edit_on;
    assign restart      = (flash_req && !flash_req_q) || (edit_mask != edit_mask_q);

    blink_tick_gen #(.HALF_PERIOD(HALF_PERIOD)) u_tick (
        .clock_i     (clock),
        .reset_i     (reset),
        .enable_i    (phase_active),
        .restart_i   (restart),
        .phase_o     (blink_phase),
        .eff_phase_o (eff_phase),
        .rise_o      (rise)
    );

    // Burst counts completed blinks; once latched, flash digits stay solid on.
    always_comb begin
        burst_cnt_d     = burst_cnt_q;
        burst_latched_d = burst_latched_q;
        burst_done_d    = 1'b0;
        if (!flash_req || (mode != mode_q)) begin
            burst_cnt_d     = '0;
            burst_latched_d = 1'b0;
        end else if ((BURST_CYCLES != 0) && rise && !burst_latched_q) begin
            if (burst_cnt_q + BW'(1) == BURST_LAST) begin
                burst_cnt_d     = BURST_LAST;
                burst_latched_d = 1'b1;
                burst_done_d    = 1'b1;
            end else begin
                burst_cnt_d = burst_cnt_q + BW'(1);
            end
        end
    end

    always_comb begin
        digit_en_d = '1;
        for (int i = 0; i < int'(N_DIGITS); i++) begin
            if (is_blank)                             digit_en_d[i] = 1'b0;
            else if (edit_mask[i])                    digit_en_d[i] = eff_phase;
            else if (flash_req && !burst_latched_q)   digit_en_d[i] = eff_phase;
            else                                      digit_en_d[i] = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            flash_req_q     <= 1'b0;
            edit_mask_q     <= '0;
            mode_q          <= MODE_SOLID;
            burst_cnt_q     <= '0;
            burst_latched_q <= 1'b0;
            burst_done_q    <= 1'b0;
            digit_en_q      <= '1;
        end else begin
            flash_req_q     <= flash_req;
            edit_mask_q     <= edit_mask;
            mode_q          <= mode;
            burst_cnt_q     <= burst_cnt_d;
            burst_latched_q <= burst_latched_d;
            burst_done_q    <= burst_done_d;
            digit_en_q      <= digit_en_d;
        end
    end

    assign digit_en   = digit_en_q;
    assign burst_done = burst_done_q;

endmodule

// File: tb/tb_stopwatch_blink_ctrl.sv
// Bench for stopwatch_blink_ctrl: three instances (HP=4 N=4, HP=4 N=4 burst=2,
// HP=3 N=6) driven by directed vectors, checked through an expected queue.
module tb_stopwatch_blink_ctrl;
  localparam int W = 10;
  localparam logic [1:0] SEL_A = 2'd0;
  localparam logic [1:0] SEL_B = 2'd1;
  localparam logic [1:0] SEL_C = 2'd2;

  // clock / reset / inputs
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        count_up_enable = 1'b0;
  logic        count_down_enable = 1'b0;
  logic [15:0] digits4 = 16'h0000;
  logic [23:0] digits6 = 24'h100000;
  logic [1:0]  mode = 2'd1;
  logic [3:0]  edit4 = 4'h0;
  logic [5:0]  edit6 = 6'h00;

  logic [3:0] en_a, en_b;
  logic [5:0] en_c;
  logic       ph_a, ph_b, ph_c, bd_a, bd_b, bd_c;

  always #5 clock = ~clock;

  stopwatch_blink_ctrl #(.HALF_PERIOD(4), .N_DIGITS(4), .BURST_CYCLES(0)) dut_a (
    .clock(clock), .reset(reset), .count_up_enable(count_up_enable),
    .count_down_enable(count_down_enable), .digits(digits4), .mode(mode),
    .edit_mask(edit4), .digit_en(en_a), .blink_phase(ph_a), .burst_done(bd_a));

  stopwatch_blink_ctrl #(.HALF_PERIOD(4), .N_DIGITS(4), .BURST_CYCLES(2)) dut_b (
    .clock(clock), .reset(reset), .count_up_enable(count_up_enable),
    .count_down_enable(count_down_enable), .digits(digits4), .mode(mode),
    .edit_mask(edit4), .digit_en(en_b), .blink_phase(ph_b), .burst_done(bd_b));

  stopwatch_blink_ctrl #(.HALF_PERIOD(3), .N_DIGITS(6), .BURST_CYCLES(0)) dut_c (
    .clock(clock), .reset(reset), .count_up_enable(count_up_enable),
    .count_down_enable(count_down_enable), .digits(digits6), .mode(mode),
    .edit_mask(edit6), .digit_en(en_c), .blink_phase(ph_c), .burst_done(bd_c));

  // scoreboard: entry = {sel[1:0], burst_done, blink_phase, digit_en[5:0]}
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks = 0;
  int           failures = 0;

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      logic [7:0]   act;
      string        nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      case (e[9:8])
        SEL_A:   act = {bd_a, ph_a, 2'b00, en_a};
        SEL_B:   act = {bd_b, ph_b, 2'b00, en_b};
        default: act = {bd_c, ph_c, en_c};
      endcase
      checks++;
      if (act !== e[7:0]) begin
        failures++;
        $display("FAIL %s t=%0t: got bd=%b ph=%b en=%h, expected bd=%b ph=%b en=%h",
                 nm, $time, act[7], act[6], act[5:0], e[7], e[6], e[5:0]);
      end
    end
  end

  // driver tasks
  task automatic tick(input logic chk, input logic [W-1:0] e, input string nm);
    @(posedge clock);
    #1;
    if (chk) begin
      exp_q.push_back(e);
      name_q.push_back(nm);
    end
  endtask

  task automatic steady(input logic [1:0] sel, input logic [5:0] en, input int n, input string nm);
    for (int k = 0; k < n; k++) tick(1'b1, {sel, 1'b0, 1'b1, en}, nm);
  endtask

  // k counts edges after the restart edge (k=1). Phase drops after HALF_PERIOD
  // edges; digit_en follows the phase one edge later. burst_k > 0 marks the
  // edge that completes the burst, after which digits are solid on.
  task automatic flash_run(input logic [1:0] sel, input int h, input logic [5:0] on_v,
                           input logic [5:0] off_v, input int n, input int burst_k,
                           input string nm);
    for (int k = 1; k <= n; k++) begin
      logic ph, en_on, bd;
      ph    = ((k / h) % 2) == 0;
      en_on = (((k - 1) / h) % 2) == 0;
      bd    = (k == burst_k);
      if (burst_k > 0 && k > burst_k) begin
        ph    = 1'b1;
        en_on = 1'b1;
      end
      tick(1'b1, {sel, bd, ph, en_on ? on_v : off_v}, nm);
    end
  endtask

  initial begin
    // reset state
    tick(1'b0, '0, "");
    tick(1'b1, {SEL_A, 1'b0, 1'b1, 6'h0F}, "reset_a");
    tick(1'b1, {SEL_B, 1'b0, 1'b1, 6'h0F}, "reset_b");
    tick(1'b1, {SEL_C, 1'b0, 1'b1, 6'h3F}, "reset_c");

    // zero-flash after release
    reset = 1'b0;
    flash_run(SEL_A, 4, 6'h0F, 6'h00, 16, 0, "zero_flash");

    // counting stops flashing; idle at zero restarts in on phase
    count_up_enable = 1'b1;
    steady(SEL_A, 6'h0F, 4, "count_up_solid");
    count_up_enable = 1'b0;
    flash_run(SEL_A, 4, 6'h0F, 6'h00, 8, 0, "reflash");
    count_down_enable = 1'b1;
    steady(SEL_A, 6'h0F, 3, "count_down_solid");
    count_down_enable = 1'b0;
    flash_run(SEL_A, 4, 6'h0F, 6'h00, 6, 0, "reflash2");

    // finite burst, then rerun after a mode change
    mode = 2'd0;
    digits4 = 16'h1234;
    steady(SEL_B, 6'h0F, 2, "solid_b");
    mode = 2'd2;
    flash_run(SEL_B, 4, 6'h0F, 6'h00, 20, 16, "burst1");
    mode = 2'd0;
    steady(SEL_B, 6'h0F, 2, "solid_between");
    mode = 2'd2;
    flash_run(SEL_B, 4, 6'h0F, 6'h00, 18, 16, "burst2");

    // edit cursor blink in SOLID, then blank
    mode = 2'd0;
    steady(SEL_A, 6'h0F, 2, "solid_a");
    edit4 = 4'b0100;
    flash_run(SEL_A, 4, 6'h0F, 6'h0B, 12, 0, "edit_blink");
    mode = 2'd3;
    steady(SEL_A, 6'h00, 3, "blank");

    // reset during a burst
    mode = 2'd0;
    edit4 = 4'h0;
    steady(SEL_B, 6'h0F, 2, "solid_pre_reset");
    mode = 2'd2;
    flash_run(SEL_B, 4, 6'h0F, 6'h00, 1, 0, "burst_start");
    reset = 1'b1;
    steady(SEL_B, 6'h0F, 3, "mid_burst_reset");
    reset = 1'b0;
    flash_run(SEL_B, 4, 6'h0F, 6'h00, 18, 16, "burst_after_reset");

    // six digits, HALF_PERIOD=3
    mode = 2'd1;
    tick(1'b0, '0, "");
    tick(1'b0, '0, "");
    steady(SEL_C, 6'h3F, 4, "top_digit_nonzero");
    digits6 = 24'h000000;
    flash_run(SEL_C, 3, 6'h3F, 6'h00, 12, 0, "six_digit_flash");

    @(negedge clock);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no completion by %0t, expected completion", $time);
    $fatal(1, "timeout");
  end

endmodule
